// File: rtl/adc_code_to_bcd_if.sv
// Handshake/result bundle between a conversion requester and adc_code_to_bcd.
// The requester (master) drives start/Din; the converter (slave) returns status and result.
interface adc_code_to_bcd_if #(
  parameter int INWIDTH = 16
);
  logic               start;
  logic [INWIDTH-1:0] Din;
  logic               busy;
  logic               done;
  logic [15:0]        bcd;
  logic               sat;

  modport master (
    output start, Din,
    input  busy, done, bcd, sat
  );

  modport slave (
    input  start, Din,
    output busy, done, bcd, sat
  );
endinterface

// File: rtl/adc_code_to_bcd.sv
// Scales an averaged ADC code to millivolts, clamps to four digits, and converts the
// result to packed BCD with a bit-serial double-dabble (one bit per enabled clock).
module adc_code_to_bcd #(
  parameter int INWIDTH = 16,
  parameter int SCALE   = 5000,
  parameter int SHIFT   = 12,
  parameter int MAXVAL  = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  adc_code_to_bcd_if.slave  bus
);

  localparam int              PW       = INWIDTH + 16;
  localparam logic [15:0]     SCALE_16 = 16'(SCALE);
  localparam logic [PW-1:0]   MAX_PW   = PW'(MAXVAL);
  localparam logic [13:0]     MAX_14   = 14'(MAXVAL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCALE,
    ST_CLAMP,
    ST_SHIFT,
    ST_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [INWIDTH-1:0] din_q, din_d;
  logic [PW-1:0]      product_q, product_d;
  logic [13:0]        sr_q, sr_d;
  logic [15:0]        scratch_q, scratch_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               sat_nxt_q, sat_nxt_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               sat_q, sat_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [14:0]        clamp_res;

  // Returns {saturated, value}; the scaled value is clamped to the four-digit ceiling.
  function automatic logic [14:0] clamp_code(input logic [PW-1:0] v);
    if (v > MAX_PW) begin
      return {1'b1, MAX_14};
    end
    return {1'b0, v[13:0]};
  endfunction

  // Double-dabble correction: every digit >= 5 gets +3 before the next left shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    product_d = product_q;
    sr_d      = sr_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sat_nxt_d = sat_nxt_q;
    bcd_d     = bcd_q;
    sat_d     = sat_q;
    done_d    = 1'b0;
    clamp_res = clamp_code(product_q >> SHIFT);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          din_d   = bus.Din;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        product_d = {16'd0, din_q} * {{INWIDTH{1'b0}}, SCALE_16};
        state_d   = ST_CLAMP;
      end
      ST_CLAMP: begin
        sat_nxt_d = clamp_res[14];
        sr_d      = clamp_res[13:0];
        scratch_d = 16'd0;
        cnt_d     = 4'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        {scratch_d, sr_d} = {dabble_adjust(scratch_q), sr_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        bcd_d   = scratch_q;
        sat_d   = sat_nxt_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Single register stage; EN=0 freezes every flop, including a pending done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      product_q <= '0;
      sr_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sat_nxt_q <= 1'b0;
      bcd_q     <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (EN) begin
      state_q   <= state_d;
      din_q     <= din_d;
      product_q <= product_d;
      sr_q      <= sr_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sat_nxt_q <= sat_nxt_d;
      bcd_q     <= bcd_d;
      sat_q     <= sat_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.sat  = sat_q;

endmodule

// File: tb/tb_adc_code_to_bcd.sv
// Directed bench for adc_code_to_bcd: reset, scaling/BCD results, saturation,
// start handshake, clock enable pause and mid-conversion abort.
module tb_adc_code_to_bcd;

  logic clk = 1'b0;
  logic reset;
  logic EN;
  int   checks = 0;
  int   errors = 0;

  adc_code_to_bcd_if #(.INWIDTH(16)) bus ();

  adc_code_to_bcd #(
    .INWIDTH(16),
    .SCALE  (5000),
    .SHIFT  (12),
    .MAXVAL (9999)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .EN   (EN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and returns the edge count from acceptance to done (-1 on timeout).
  task automatic run_conv(input logic [15:0] d, output int lat);
    bus.Din   = d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; EN = 1'b1; bus.start = 1'b0; bus.Din = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus.bcd, bus.sat, bus.done, bus.busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_por: bcd=%h sat=%b done=%b busy=%b, want all 0", bus.bcd, bus.sat, bus.done, bus.busy);
    end
    // Reset asserted in the middle of a conversion.
    bus.Din = 16'h0800; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (bus.bcd !== 16'h0000 || bus.sat !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: bcd=%h sat=%b done=%b busy=%b, want 0000/0/0/0", bus.bcd, bus.sat, bus.done, bus.busy);
    end
    run_conv(16'd1, lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL reset_first_latency: got %0d, want 17", lat);
    end
    checks++;
    if (bus.bcd !== 16'h0001) begin
      errors++;
      $display("FAIL reset_first_bcd: got %h, want 0001", bus.bcd);
    end
  endtask

  task automatic test_nominal();
    int lat;
    int bad_busy;
    tick();
    bus.Din = 16'h0800; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bad_busy = 0;
    // After edges k .. k+16: busy high, done low.
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
    end
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL nominal_busy_window: %0d cycles with busy!=1 or done!=0, want 0", bad_busy);
    end
    tick(); // edge k+17
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done_edge: done=%b busy=%b, want done=1 busy=0", bus.done, bus.busy);
    end
    checks++;
    if (bus.bcd !== 16'h2500 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL nominal_2048: bcd=%h sat=%b, want 2500/0", bus.bcd, bus.sat);
    end
    tick(); // edge k+18
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done_pulse: done=%b after one cycle, want 0", bus.done);
    end
    run_conv(16'd4095, lat);
    checks++;
    if (lat !== 17 || bus.bcd !== 16'h4998 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL nominal_4095: lat=%0d bcd=%h sat=%b, want 17/4998/0", lat, bus.bcd, bus.sat);
    end
    run_conv(16'd0, lat);
    checks++;
    if (lat !== 17 || bus.bcd !== 16'h0000 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL nominal_zero: lat=%0d bcd=%h sat=%b, want 17/0000/0", lat, bus.bcd, bus.sat);
    end
  endtask

  task automatic test_saturation();
    int lat;
    run_conv(16'hFFFF, lat);
    checks++;
    if (lat !== 17 || bus.bcd !== 16'h9999 || bus.sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_ffff: lat=%0d bcd=%h sat=%b, want 17/9999/1", lat, bus.bcd, bus.sat);
    end
    run_conv(16'h0400, lat);
    checks++;
    if (lat !== 17 || bus.bcd !== 16'h1250 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear_0400: lat=%0d bcd=%h sat=%b, want 17/1250/0", lat, bus.bcd, bus.sat);
    end
  endtask

  task automatic test_start_while_busy();
    int dones;
    int first;
    tick();
    bus.Din = 16'h0800; bus.start = 1'b1;
    tick(); // edge k
    bus.start = 1'b0;
    dones = 0; first = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        bus.Din = 16'd100; bus.start = 1'b1;
      end
      tick();
      if (n == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (dones !== 1 || first !== 17) begin
      errors++;
      $display("FAIL busy_start_ignored: dones=%0d first=%0d, want 1 at 17", dones, first);
    end
    checks++;
    if (bus.bcd !== 16'h2500) begin
      errors++;
      $display("FAIL busy_start_result: bcd=%h, want 2500", bus.bcd);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din_tab [3] = '{16'h0800, 16'h0400, 16'd4095};
    logic [15:0] exp_tab [3] = '{16'h2500, 16'h1250, 16'h4998};
    int last;
    int idx;
    int n;
    bus.Din = din_tab[0]; bus.start = 1'b1;
    tick(); // first acceptance at n=0
    last = 0; idx = 0; n = 0;
    while (idx < 3 && n < 100) begin
      tick();
      n++;
      if (bus.done === 1'b1) begin
        checks++;
        if (bus.bcd !== exp_tab[idx] || (n - last) !== ((idx == 0) ? 17 : 18)) begin
          errors++;
          $display("FAIL b2b_%0d: bcd=%h gap=%0d, want %h gap %0d", idx, bus.bcd, n - last,
                   exp_tab[idx], (idx == 0) ? 17 : 18);
        end
        last = n;
        idx++;
        if (idx < 3) bus.Din = din_tab[idx];
      end
    end
    bus.start = 1'b0;
    checks++;
    if (idx !== 3) begin
      errors++;
      $display("FAIL b2b_timeout: %0d results seen, want 3", idx);
    end
    tick();
  endtask

  task automatic test_enable();
    logic [15:0] snap;
    int bad;
    int n;
    int got;
    run_conv(16'h0400, n); // known prior result 1250
    tick();
    snap = bus.bcd;
    bus.Din = 16'd2048; bus.start = 1'b1;
    tick(); // edge k
    bus.start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    EN = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.Din = 16'hFFFF;
      tick();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bcd !== snap) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL enable_pause_hold: %0d cycles changed, want 0 (bcd=%h want %h)", bad, bus.bcd, snap);
    end
    EN = 1'b1;
    n = 17; got = -1;
    while (n < 60) begin
      tick();
      n++;
      if (bus.done === 1'b1) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got !== 27 || bus.bcd !== 16'h2500) begin
      errors++;
      $display("FAIL enable_latency: done at %0d bcd=%h, want 27/2500", got, bus.bcd);
    end
    // A done pulse already high is held while disabled.
    EN = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL enable_done_hold: done=%b, want 1", bus.done);
    end
    EN = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL enable_done_clear: done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_abort();
    int dones;
    int lat;
    bus.Din = 16'd4095; bus.start = 1'b1;
    tick(); // edge k
    bus.start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    reset = 1'b1;
    tick(); // edge k+10
    reset = 1'b0;
    checks++;
    if (bus.bcd !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: bcd=%h busy=%b done=%b sat=%b, want 0000/0/0/0", bus.bcd, bus.busy, bus.done, bus.sat);
    end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.bcd !== 16'h0000) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles bcd=%h, want 0/0000", dones, bus.bcd);
    end
    run_conv(16'd2048, lat);
    checks++;
    if (lat !== 17 || bus.bcd !== 16'h2500) begin
      errors++;
      $display("FAIL abort_restart: lat=%0d bcd=%h, want 17/2500", lat, bus.bcd);
    end
  endtask

  task automatic test_small_value();
    int lat;
    run_conv(16'd100, lat);
    checks++;
    if (lat !== 17 || bus.bcd !== 16'h0122 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL small_100: lat=%0d bcd=%h sat=%b, want 17/0122/0", lat, bus.bcd, bus.sat);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_start_while_busy();
    test_back_to_back();
    test_enable();
    test_abort();
    test_small_value();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
